// File: rtl/byte_reg_write_seq.sv
// Two-requester masked word-write arbiter and byte serialiser for a byte-writable register bank.
// Define BYTE_SEQ_FIXED_PRIORITY_EN to make requester 0 win all contention instead of round-robin.
module byte_reg_write_seq #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [31:0]           req0_data,
    input  logic [3:0]            req0_be,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [31:0]           req1_data,
    input  logic [3:0]            req1_be,
    output logic [NUM_REGS-1:0]   reg_we,
    output logic [1:0]            byte_sel,
    output logic [7:0]            byte_in,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic                  done_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state;
    logic                  last_grant;
    logic                  owner_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [3:0]            mask_q;

    logic       win;
    logic       accept;
    logic [1:0] idx;
    logic [3:0] mask_nxt;
    logic       addr_ok;

    always_comb begin
        win = 1'b0;
`ifdef BYTE_SEQ_FIXED_PRIORITY_EN
        win = !req0_valid;
`else
        if (req0_valid && req1_valid)
            win = !last_grant;
        else
            win = req1_valid;
`endif
    end

    assign req0_ready = (state == IDLE) && !rst && req0_valid && !win;
    assign req1_ready = (state == IDLE) && !rst && req1_valid && win;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        casez (mask_q)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
    end

    assign mask_nxt = mask_q & ~(4'b0001 << idx);
    assign addr_ok  = ({{(32-ADDR_WIDTH){1'b0}}, addr_q} < 32'(NUM_REGS));

    // Side-effect outputs are gated by rst so an aborted transaction writes nothing more.
    always_comb begin
        reg_we   = '0;
        byte_sel = '0;
        byte_in  = '0;
        done     = 1'b0;
        done_id  = 1'b0;
        done_err = 1'b0;
        busy     = (state != IDLE);
        if (state == WRITE) begin
            byte_sel = idx;
            byte_in  = data_q[{idx, 3'b000} +: 8];
            for (int unsigned i = 0; i < NUM_REGS; i++)
                reg_we[i] = !rst && (addr_q == ADDR_WIDTH'(i));
        end else if (state == DONE && !rst) begin
            done     = 1'b1;
            done_id  = owner_q;
            done_err = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_q    <= win;
                        last_grant <= win;
                        err_q      <= 1'b0;
                        addr_q     <= win ? req1_addr : req0_addr;
                        data_q     <= win ? req1_data : req0_data;
                        mask_q     <= win ? req1_be   : req0_be;
                        state      <= ((win ? req1_be : req0_be) != 4'b0000) ? WRITE : DONE;
                    end
                end
                WRITE: begin
                    mask_q <= mask_nxt;
                    if (!addr_ok)
                        err_q <= 1'b1;
                    if (mask_nxt == 4'b0000)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_reg_write_seq.sv
// Bench for byte_reg_write_seq (NUM_REGS=6): directed vector table, hand sequences, random vs queue model.
module tb_byte_reg_write_seq;

    localparam int NR = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [31:0]   req0_data, req1_data;
    logic [3:0]    req0_be, req1_be;
    logic [NR-1:0] reg_we;
    logic [1:0]    byte_sel;
    logic [7:0]    byte_in;
    logic          busy, done, done_id, done_err;

    int n_chk  = 0;
    int n_fail = 0;

    byte_reg_write_seq #(.NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_be(req0_be),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_be(req1_be),
        .reg_we(reg_we), .byte_sel(byte_sel), .byte_in(byte_in),
        .busy(busy), .done(done), .done_id(done_id), .done_err(done_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           id;
        logic [2:0]     addr;
        logic [31:0]    data;
        logic [3:0]     be;
        int             k;
        logic [5:0]     we;
        logic [3:0][9:0] wr;   // {sel, byte} per write cycle, entry 0 first
        logic           err;
    } vec_t;

    typedef struct packed {
        logic [5:0] we;
        logic [1:0] sel;
        logic [7:0] bv;
        logic       dn;
        logic       id;
        logic       err;
    } rec_t;

    vec_t vecs[6];
    rec_t q[$];
    logic m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] outs();
        return {req0_ready, req1_ready, reg_we, byte_sel, byte_in, busy, done, done_id, done_err};
    endfunction

    function automatic logic rdy(input logic id);
        return id ? req1_ready : req0_ready;
    endfunction

    task automatic set_req(input logic id, input logic v, input logic [2:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        if (id) begin
            req1_valid = v; req1_addr = a; req1_data = d; req1_be = be;
        end else begin
            req0_valid = v; req0_addr = a; req0_data = d; req0_be = be;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", ok, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        logic got;
        step();
        set_req(v.id, 1'b1, v.addr, v.data, v.be);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rdy(v.id)) begin
                got = 1'b1;
                break;
            end
        end
        check("vec_accept", got, 1'b1);
        step();
        set_req(v.id, 1'b0, 3'($urandom), $urandom, 4'($urandom));
        for (int j = 0; j < v.k; j++) begin
            @(negedge clk);
            check("vec_write", {reg_we, byte_sel, byte_in, done}, {v.we, v.wr[j], 1'b0});
        end
        @(negedge clk);
        check("vec_done", {done, done_id, done_err, reg_we, busy}, {1'b1, v.id, v.err, 6'b0, 1'b1});
        step();
        set_req(v.id, 1'b1, v.addr, v.data, v.be);
        @(negedge clk);
        check("vec_ready_again", rdy(v.id), 1'b1);
        set_req(v.id, 1'b0, v.addr, v.data, v.be);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] grants;
        int         gcyc[4];
        int         ng;
        logic       sticky;
        logic [21:0] expv;
        rec_t       e;
        logic       v0, v1, w, acc;
        logic [2:0] a;
        logic [31:0] d;
        logic [3:0] be;
        logic [1:0] bsel;

        vecs[0] = '{1'b0, 3'd2, 32'hA1B2C3D4, 4'hF, 4, 6'b000100,
                    {10'h3A1, 10'h2B2, 10'h1C3, 10'h0D4}, 1'b0};
        vecs[1] = '{1'b1, 3'd5, 32'h11223344, 4'hA, 2, 6'b100000,
                    {10'h000, 10'h000, 10'h311, 10'h133}, 1'b0};
        vecs[2] = '{1'b0, 3'd3, 32'h99887766, 4'h0, 0, 6'b001000,
                    {10'h000, 10'h000, 10'h000, 10'h000}, 1'b0};
        vecs[3] = '{1'b1, 3'd7, 32'h55667788, 4'h3, 2, 6'b000000,
                    {10'h000, 10'h000, 10'h177, 10'h088}, 1'b1};
        vecs[4] = '{1'b0, 3'd0, 32'hDEADBEEF, 4'h4, 1, 6'b000001,
                    {10'h000, 10'h000, 10'h000, 10'h2AD}, 1'b0};
        vecs[5] = '{1'b1, 3'd4, 32'h0F0E0D0C, 4'h9, 2, 6'b010000,
                    {10'h000, 10'h000, 10'h30F, 10'h00C}, 1'b0};

        // Reset: ready must stay low even with both requesters valid.
        rst = 1'b1;
        set_req(1'b0, 1'b1, 3'd1, 32'h0, 4'hF);
        set_req(1'b1, 1'b1, 3'd2, 32'h0, 4'hF);
        step();
        @(negedge clk);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        step();
        rst = 1'b0;
        set_req(1'b0, 1'b0, 3'd1, 32'h0, 4'hF);
        set_req(1'b1, 1'b0, 3'd2, 32'h0, 4'hF);
        @(negedge clk);
        check("reset_state", outs(), 22'h0);

        // Contention from reset with both requesters held valid.
        step();
        set_req(1'b0, 1'b1, 3'd1, 32'h01020304, 4'hF);
        set_req(1'b1, 1'b1, 3'd2, 32'h05060708, 4'hF);
        ng = 0;
        grants = '0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                grants[ng] = req1_ready;
                gcyc[ng] = c;
                ng++;
            end
        end
        check("contention_count", ng, 4);
`ifdef BYTE_SEQ_FIXED_PRIORITY_EN
        check("contention_order", grants, 4'b0000);
`else
        check("contention_order", grants, 4'b1010);
`endif
        for (int i = 1; i < ng; i++)
            check("contention_period", gcyc[i] - gcyc[i-1], 6);
        step();
        set_req(1'b0, 1'b0, 3'd1, 32'h0, 4'h0);
        set_req(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        wait_idle();

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i]);

        // Reset after the second byte of a full-word write.
        step();
        set_req(1'b0, 1'b1, 3'd1, 32'h01020304, 4'hF);
        @(negedge clk);
        check("rstmid_accept", req0_ready, 1'b1);
        step();
        set_req(1'b0, 1'b0, 3'd1, 32'h0, 4'h0);
        @(negedge clk);
        check("rstmid_b0", {reg_we, byte_sel, byte_in}, {6'b000010, 2'd0, 8'h04});
        @(negedge clk);
        check("rstmid_b1", {reg_we, byte_sel, byte_in}, {6'b000010, 2'd1, 8'h03});
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_during", {reg_we, done, req0_ready, req1_ready}, 9'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_after", outs(), 22'h0);
        sticky = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sticky = sticky | done | (|reg_we);
        end
        check("rstmid_no_done", sticky, 1'b0);

        // Randomized traffic against a queue-of-scheduled-outputs reference model.
        m_last = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
            for (int r = 0; r < 2; r++) begin
                a  = 3'($urandom);
                be = 4'($urandom);
                if (a >= 3'(NR) && be == 4'h0) be = 4'h1;
                set_req(r[0], 1'($urandom_range(0, 1)), a, $urandom, be);
            end
            @(negedge clk);
            if (rst) begin
                check("rand_rst", {reg_we, done, req0_ready, req1_ready}, 9'h0);
                q.delete();
                m_last = 1'b1;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                expv = {2'b00, e.we, e.sel, e.bv, 1'b1, e.dn, e.id, e.err};
                check("rand_cycle", outs(), expv);
            end else begin
                v0 = req0_valid;
                v1 = req1_valid;
`ifdef BYTE_SEQ_FIXED_PRIORITY_EN
                w = !v0;
`else
                w = (v0 && v1) ? !m_last : v1;
`endif
                acc = w ? v1 : v0;
                expv = {acc && !w, acc && w, 20'h0};
                check("rand_cycle", outs(), expv);
                if (acc) begin
                    a  = w ? req1_addr : req0_addr;
                    d  = w ? req1_data : req0_data;
                    be = w ? req1_be : req0_be;
                    m_last = w;
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            bsel = 2'(b);
                            e.we  = (int'(a) < NR) ? 6'(1 << a) : 6'b0;
                            e.sel = bsel;
                            e.bv  = d[8*b +: 8];
                            e.dn  = 1'b0;
                            e.id  = 1'b0;
                            e.err = 1'b0;
                            q.push_back(e);
                        end
                    end
                    e = '{6'b0, 2'b0, 8'h0, 1'b1, w, (int'(a) >= NR) && (be != 4'h0)};
                    q.push_back(e);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
